cpu_run_controller: RTL and testbench
=====================================

CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 Parameter CLK_FREQUENCY_HZ, default 8000000, input clock rate used to derive run-rate tick periods.
REQ-002 Parameter SIMULATE, default 0; 1 SHALL shorten tick periods to 256/64/16/4 cycles for rate_sel 00/01/10/11.
REQ-003 clk_8MHz  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 step_btn  input  1  debounced step button level; rising edge = step request.
REQ-006 run_btn  input  1  debounced run button level; rising edge = run/stop toggle.
REQ-007 rate_sel  input  2  run rate: 00=1 Hz, 01=4 Hz, 10=16 Hz, 11=64 Hz.
REQ-008 bp_en  input  1  breakpoint enable.
REQ-009 bp_addr  input  PC_WIDTH_DEF  breakpoint PC.
REQ-010 pc  input  PC_WIDTH_DEF  CPU program counter.
REQ-011 valid_result, halt, error  input  1 each  CPU status.
REQ-012 single_step  output  1  one-cycle step pulse to CPU.
REQ-013 running  output  1  free-run mode active.
REQ-014 bp_hit  output  1  sticky; stopped at breakpoint.
REQ-015 timeout  output  1  sticky; no valid_result after a step.
REQ-016 step_count  output  16  steps issued since reset.

Function
REQ-017 Button edges SHALL be level & ~registered previous level; the edge is seen one cycle after the level rises.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RUN_DLY, STOP.
REQ-019 IDLE: run edge with halt=0 and error=0 -> RUN_DLY, running=1, tick counter=0; else step edge with halt=0 and error=0 -> ISSUE; simultaneous edges: run wins.
REQ-020 ISSUE: single_step=1 for exactly this one cycle; step_count+1, wrapping 0xFFFF->0x0000; watchdog=0; next WAIT.
REQ-021 WAIT: valid_result -> RUN_DLY if running, else IDLE; halt or error -> STOP; 1024 cycles with no valid_result -> timeout=1, running=0, IDLE.
REQ-022 RUN_DLY: tick counter increments; counter >= period-1 -> ISSUE (>= so a rate_sel change mid-period takes effect at once); run edge -> running=0, IDLE.
REQ-023 Breakpoint: in RUN_DLY at tick expiry, bp_en=1 and pc==bp_addr and skip flag clear -> STOP, bp_hit=1, running=0, no step issued.
REQ-024 halt or error high in IDLE, RUN_DLY or WAIT SHALL force STOP on the next edge with running=0; ISSUE still completes its pulse.
REQ-025 STOP with halt or error high: no single_step ever; all button edges ignored.
REQ-026 STOP with halt=0 and error=0 (breakpoint stop): step edge -> ISSUE, bp_hit cleared; run edge -> RUN_DLY, running=1, skip flag set, bp_hit cleared.
REQ-027 Skip flag SHALL clear after the first ISSUE following a breakpoint resume.
REQ-028 Step edges while running=1 SHALL be ignored.
REQ-029 timeout SHALL clear only on the next step or run edge accepted from IDLE.

Reset
REQ-030 resetn=0 SHALL asynchronously force IDLE and set single_step, running, bp_hit, timeout, step_count, tick counter, watchdog and skip flag to 0.
REQ-031 Previous-level edge registers SHALL reset to 1, so a button held through reset release produces no edge.

Configuration
REQ-032 Macro RUNCTL_BREAKPOINT_EN defined: REQ-023, REQ-026 breakpoint resume and REQ-027 SHALL be present.
REQ-033 Macro undefined: bp_en and bp_addr SHALL be ignored, bp_hit SHALL be tied 0, and STOP SHALL be entered only through halt or error.

Structure
REQ-034 stackCPU_DEFS SHALL hold the runctl_state_t enum, RUNCTL_WDOG_CYCLES=1024, and the simulation tick periods; PC width SHALL use PC_WIDTH_DEF.
REQ-035 Rate divider SHALL be the sub-module runctl_tick_gen (rate_sel in, period-expired flag out, synchronous clear).

Verification (SIMULATE=1)
REQ-036 Step edge, valid_result 3 cycles after the pulse -> exactly one single_step pulse, step_count=1, return to IDLE.
REQ-037 Run edge, rate_sel=11, CPU answering in 2 cycles -> single_step pulses spaced 4+1+2 cycles apart; second run edge -> running=0 with no further pulses.
REQ-038 Run with bp_en=1, bp_addr=0x05, pc incrementing per step -> stop with pc=0x05 and bp_hit=1; run edge -> step at 0x05 issued, next stop occurs only on a later match.
REQ-039 Step with valid_result never asserted -> timeout=1 after 1024 cycles; next step edge clears timeout.
REQ-040 halt asserted while running -> STOP within 1 cycle, running=0; step and run edges produce no pulse; resetn pulse mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/stackCPU_DEFS.sv
// Shared definitions for the CPU run controller: FSM state type, watchdog
// length, PC width and the run-rate period lookup.
package stackCPU_DEFS;

   localparam int unsigned PC_WIDTH_DEF       = 8;
   localparam int unsigned RUNCTL_WDOG_CYCLES = 1024;

   // Shortened tick periods used when SIMULATE=1 (rate_sel 00/01/10/11).
   localparam int unsigned RUNCTL_SIM_PERIOD_1HZ  = 256;
   localparam int unsigned RUNCTL_SIM_PERIOD_4HZ  = 64;
   localparam int unsigned RUNCTL_SIM_PERIOD_16HZ = 16;
   localparam int unsigned RUNCTL_SIM_PERIOD_64HZ = 4;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RUN_DLY,
      STOP
   } runctl_state_t;

   function automatic logic [31:0] runctl_period(input logic [1:0]  rate_sel,
                                                 input int unsigned clk_hz,
                                                 input int unsigned simulate);
      logic [31:0] p;
      p = clk_hz;
      if (simulate != 0) begin
         case (rate_sel)
            2'b00:   p = RUNCTL_SIM_PERIOD_1HZ;
            2'b01:   p = RUNCTL_SIM_PERIOD_4HZ;
            2'b10:   p = RUNCTL_SIM_PERIOD_16HZ;
            default: p = RUNCTL_SIM_PERIOD_64HZ;
         endcase
      end else begin
         case (rate_sel)
            2'b00:   p = clk_hz;
            2'b01:   p = clk_hz / 32'd4;
            2'b10:   p = clk_hz / 32'd16;
            default: p = clk_hz / 32'd64;
         endcase
      end
      return p;
   endfunction

endpackage

// File: rtl/runctl_tick_gen.sv
// Run-rate divider: counts while not cleared and flags when the period for the
// current rate_sel has elapsed (compared live, so rate changes act at once).
module runctl_tick_gen
   import stackCPU_DEFS::*;
#(
   parameter int unsigned CLK_FREQUENCY_HZ = 8000000,
   parameter int unsigned SIMULATE         = 0
) (
   input  logic       clk_8MHz,
   input  logic       resetn,
   input  logic       clear_i,
   input  logic [1:0] rate_sel_i,
   output logic       expired_o
);

   logic [31:0] period;
   logic [31:0] cnt_q, cnt_d;

   assign period = runctl_period(rate_sel_i, CLK_FREQUENCY_HZ, SIMULATE);

   // NOTE: combinational blocks assign every output on every path, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q + 32'd1;
      if (clear_i) cnt_d = '0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_8MHz or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q >= period - 32'd1);

endmodule

// File: rtl/cpu_run_controller.sv
// Step/run front panel controller for the stack CPU: single step, free run at a
// selectable rate, watchdog timeout; breakpoint stop when RUNCTL_BREAKPOINT_EN is defined.
module cpu_run_controller
   import stackCPU_DEFS::*;
#(
   parameter int unsigned CLK_FREQUENCY_HZ = 8000000,
   parameter int unsigned SIMULATE         = 0
) (
   input  logic                    clk_8MHz,
   input  logic                    resetn,
   input  logic                    step_btn,
   input  logic                    run_btn,
   input  logic [1:0]              rate_sel,
   input  logic                    bp_en,
   input  logic [PC_WIDTH_DEF-1:0] bp_addr,
   input  logic [PC_WIDTH_DEF-1:0] pc,
   input  logic                    valid_result,
   input  logic                    halt,
   input  logic                    error,
   output logic                    single_step,
   output logic                    running,
   output logic                    bp_hit,
   output logic                    timeout,
   output logic [15:0]             step_count
);

   localparam int unsigned WDOG_W = $clog2(RUNCTL_WDOG_CYCLES);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(RUNCTL_WDOG_CYCLES - 1);

   runctl_state_t     state_q;
   logic              step_prev_q, run_prev_q;
   logic              single_step_q, running_q, bp_hit_q, timeout_q, skip_q;
   logic [15:0]       step_count_q;
   logic [WDOG_W-1:0] wdog_q;

   logic step_edge, run_edge, cpu_stop, tick_expired, bp_match;

   assign step_edge = step_btn & ~step_prev_q;
   assign run_edge  = run_btn & ~run_prev_q;
   assign cpu_stop  = halt | error;

   runctl_tick_gen #(
      .CLK_FREQUENCY_HZ(CLK_FREQUENCY_HZ),
      .SIMULATE        (SIMULATE)
   ) u_tick (
      .clk_8MHz  (clk_8MHz),
      .resetn    (resetn),
      .clear_i   (state_q != RUN_DLY),
      .rate_sel_i(rate_sel),
      .expired_o (tick_expired)
   );

`ifdef RUNCTL_BREAKPOINT_EN
   assign bp_match = bp_en && (pc == bp_addr) && !skip_q;
`else
   logic unused_bp;
   assign unused_bp = ^{bp_en, bp_addr, pc, skip_q};
   assign bp_match  = 1'b0;
`endif

   always_ff @(posedge clk_8MHz or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         step_prev_q   <= 1'b1;  // a button held through reset must not look like a press
         run_prev_q    <= 1'b1;
         single_step_q <= 1'b0;
         running_q     <= 1'b0;
         bp_hit_q      <= 1'b0;
         timeout_q     <= 1'b0;
         skip_q        <= 1'b0;
         step_count_q  <= '0;
         wdog_q        <= '0;
      end else begin
         step_prev_q   <= step_btn;
         run_prev_q    <= run_btn;
         single_step_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cpu_stop) begin
                  state_q   <= STOP;
                  running_q <= 1'b0;
               end else if (run_edge) begin
                  state_q   <= RUN_DLY;
                  running_q <= 1'b1;
                  timeout_q <= 1'b0;
               end else if (step_edge) begin
                  state_q       <= ISSUE;
                  single_step_q <= 1'b1;
                  timeout_q     <= 1'b0;
               end
            end
            ISSUE: begin
               state_q      <= WAIT;
               step_count_q <= step_count_q + 16'd1;
               wdog_q       <= '0;
               skip_q       <= 1'b0;
            end
            WAIT: begin
               if (cpu_stop) begin
                  state_q   <= STOP;
                  running_q <= 1'b0;
               end else if (valid_result) begin
                  state_q <= running_q ? RUN_DLY : IDLE;
               end else if (wdog_q == WDOG_LAST) begin
                  state_q   <= IDLE;
                  timeout_q <= 1'b1;
                  running_q <= 1'b0;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            RUN_DLY: begin
               if (cpu_stop) begin
                  state_q   <= STOP;
                  running_q <= 1'b0;
               end else if (run_edge) begin
                  state_q   <= IDLE;
                  running_q <= 1'b0;
               end else if (tick_expired) begin
                  if (bp_match) begin
                     state_q   <= STOP;
                     bp_hit_q  <= 1'b1;
                     running_q <= 1'b0;
                  end else begin
                     state_q       <= ISSUE;
                     single_step_q <= 1'b1;
                  end
               end
            end
            STOP: begin
               if (!cpu_stop) begin
`ifdef RUNCTL_BREAKPOINT_EN
                  if (run_edge) begin
                     state_q   <= RUN_DLY;
                     running_q <= 1'b1;
                     skip_q    <= 1'b1;
                     bp_hit_q  <= 1'b0;
                  end else if (step_edge) begin
                     state_q       <= ISSUE;
                     single_step_q <= 1'b1;
                     bp_hit_q      <= 1'b0;
                  end
`else
                  state_q <= IDLE;  // only a CPU stop exists; resume once it is released
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign single_step = single_step_q;
   assign running     = running_q;
   assign bp_hit      = bp_hit_q;
   assign timeout     = timeout_q;
   assign step_count  = step_count_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller (SIMULATE=1) with a small CPU model
// that answers each step pulse after a programmable latency.
module tb_cpu_run_controller;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        step_btn = 1'b0;
   logic        run_btn = 1'b0;
   logic [1:0]  rate_sel = 2'b11;
   logic        bp_en = 1'b0;
   logic [7:0]  bp_addr = 8'h00;
   logic [7:0]  pc = 8'h00;
   logic        valid_result = 1'b0;
   logic        halt = 1'b0;
   logic        error = 1'b0;
   logic        single_step, running, bp_hit, timeout;
   logic [15:0] step_count;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int cd = 0;
   int lat = 3;
   int pulse_cnt = 0;
   int pulse_t_prev = 0;
   int pulse_t_last = 0;

   cpu_run_controller #(
      .CLK_FREQUENCY_HZ(8000000),
      .SIMULATE        (1)
   ) dut (
      .clk_8MHz    (clk),
      .resetn      (resetn),
      .step_btn    (step_btn),
      .run_btn     (run_btn),
      .rate_sel    (rate_sel),
      .bp_en       (bp_en),
      .bp_addr     (bp_addr),
      .pc          (pc),
      .valid_result(valid_result),
      .halt        (halt),
      .error       (error),
      .single_step (single_step),
      .running     (running),
      .bp_hit      (bp_hit),
      .timeout     (timeout),
      .step_count  (step_count)
   );

   always #5 clk = ~clk;

   // CPU model: counts step pulses, answers with valid_result sampled on the
   // lat-th rising edge after the pulse cycle, and advances pc on each answer.
   always @(posedge clk) begin
      #1;
      cyc++;
      valid_result = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            valid_result = 1'b1;
            pc = pc + 8'd1;
         end
      end
      if (single_step) begin
         pulse_cnt++;
         pulse_t_prev = pulse_t_last;
         pulse_t_last = cyc;
         if (lat > 0) cd = lat;
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1, "bench timed out");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic s, input logic r);
      step_btn = s;
      run_btn  = r;
      tick(2);
      step_btn = 1'b0;
      run_btn  = 1'b0;
      tick(1);
   endtask

   task automatic wait_pulses(input int target, input int bound, input string tag);
      for (int i = 0; i < bound && pulse_cnt < target; i++) tick(1);
      check(tag, 32'(pulse_cnt >= target), 32'd1);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick(2);
      resetn = 1'b1;
      tick(2);
   endtask

   initial begin
      int base;
      int t0;
      logic [7:0]  pc0;
      logic [15:0] sc0;

      // Reset state, with the step button held across reset release
      tick(2);
      check("reset_outputs", 32'({single_step, running, bp_hit, timeout, step_count}), 32'd0);
      step_btn = 1'b1;
      resetn   = 1'b1;
      tick(10);
      check("held_btn_no_edge", 32'(pulse_cnt), 32'd0);
      step_btn = 1'b0;
      tick(2);

      // Single step, CPU answers 3 cycles after the pulse
      lat = 3;
      press(1'b1, 1'b0);
      tick(20);
      check("step_one_pulse", 32'(pulse_cnt), 32'd1);
      check("step_count_1", 32'(step_count), 32'd1);
      check("step_not_running", 32'(running), 32'd0);
      press(1'b1, 1'b0);
      tick(20);
      check("step_again_count", 32'(step_count), 32'd2);

      // Free run at 64 Hz, CPU answers in 2 cycles: pulses 4+1+2 apart
      lat = 2;
      rate_sel = 2'b11;
      base = pulse_cnt;
      press(1'b0, 1'b1);
      check("run_running", 32'(running), 32'd1);
      wait_pulses(base + 3, 100, "run64_pulses");
      check("run64_spacing", 32'(pulse_t_last - pulse_t_prev), 32'd7);
      tick(3);
      press(1'b0, 1'b1);
      base = pulse_cnt;
      tick(30);
      check("run64_stopped", 32'(running), 32'd0);
      check("run64_no_more", 32'(pulse_cnt), 32'(base));

      // Free run at 16 Hz: pulses 16+1+2 apart
      rate_sel = 2'b10;
      base = pulse_cnt;
      press(1'b0, 1'b1);
      wait_pulses(base + 2, 100, "run16_pulses");
      check("run16_spacing", 32'(pulse_t_last - pulse_t_prev), 32'd19);
      tick(3);
      press(1'b0, 1'b1);
      tick(30);
      check("run16_stopped", 32'(running), 32'd0);

      // Simultaneous edges: run wins; step edges ignored while running
      rate_sel = 2'b00;
      base = pulse_cnt;
      press(1'b1, 1'b1);
      check("both_run_wins", 32'(running), 32'd1);
      press(1'b1, 1'b0);
      tick(40);
      check("step_ignored_run", 32'(pulse_cnt), 32'(base));
      press(1'b0, 1'b1);
      tick(5);
      check("slow_run_stopped", 32'(running), 32'd0);

      // Watchdog timeout, then cleared by the next accepted step
      lat = 0;
      rate_sel = 2'b11;
      base = pulse_cnt;
      press(1'b1, 1'b0);
      wait_pulses(base + 1, 10, "wdog_pulse");
      t0 = pulse_t_last;
      for (int i = 0; i < 1100 && !timeout; i++) tick(1);
      check("timeout_set", 32'(timeout), 32'd1);
      check("timeout_latency", 32'(cyc - t0), 32'd1025);
      lat = 3;
      press(1'b1, 1'b0);
      check("timeout_cleared", 32'(timeout), 32'd0);
      tick(10);
      check("timeout_step_pulse", 32'(pulse_cnt), 32'(base + 2));

      // Breakpoint
      lat = 2;
      rate_sel = 2'b11;
      bp_en = 1'b1;
      pc0 = pc;
      sc0 = step_count;
`ifdef RUNCTL_BREAKPOINT_EN
      bp_addr = pc0 + 8'd5;
      press(1'b0, 1'b1);
      for (int i = 0; i < 200 && !bp_hit; i++) tick(1);
      check("bp_hit_set", 32'(bp_hit), 32'd1);
      check("bp_pc", 32'(pc), 32'(pc0 + 8'd5));
      check("bp_steps", 32'(step_count), 32'(sc0 + 16'd5));
      check("bp_not_running", 32'(running), 32'd0);
      base = pulse_cnt;
      press(1'b0, 1'b1);
      check("bp_resume_clear", 32'(bp_hit), 32'd0);
      wait_pulses(base + 1, 20, "bp_skip_step");
      bp_addr = pc0 + 8'd7;
      for (int i = 0; i < 200 && !bp_hit; i++) tick(1);
      check("bp2_hit", 32'(bp_hit), 32'd1);
      check("bp2_pc", 32'(pc), 32'(pc0 + 8'd7));
      check("bp2_steps", 32'(step_count), 32'(sc0 + 16'd7));
`else
      bp_addr = pc0 + 8'd2;
      base = pulse_cnt;
      press(1'b0, 1'b1);
      wait_pulses(base + 4, 100, "nobp_pulses");
      check("nobp_hit_low", 32'(bp_hit), 32'd0);
      check("nobp_running", 32'(running), 32'd1);
      tick(3);
      press(1'b0, 1'b1);
      tick(20);
      check("nobp_stopped", 32'(running), 32'd0);
`endif
      bp_en = 1'b0;
      do_reset();

      // Halt while running: STOP within one cycle, buttons then ignored
      base = pulse_cnt;
      press(1'b0, 1'b1);
      wait_pulses(base + 1, 20, "halt_first_pulse");
      tick(4);
      halt = 1'b1;
      tick(1);
      check("halt_stops_run", 32'(running), 32'd0);
      base = pulse_cnt;
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      tick(10);
      check("halt_no_pulse", 32'(pulse_cnt), 32'(base));
      check("halt_still_stopped", 32'(running), 32'd0);
      halt = 1'b0;
      do_reset();

      // Asynchronous reset in the middle of WAIT while running
      lat = 0;
      base = pulse_cnt;
      press(1'b0, 1'b1);
      wait_pulses(base + 1, 20, "rst_pulse");
      tick(3);
      check("pre_reset_running", 32'(running), 32'd1);
      check("pre_reset_count", 32'(step_count), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check("async_reset_zero", 32'({single_step, running, bp_hit, timeout, step_count}), 32'd0);
      tick(2);
      resetn = 1'b1;
      tick(2);
      lat = 3;
      press(1'b1, 1'b0);
      tick(10);
      check("post_reset_step", 32'(step_count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
